// File: rtl/fpu_mul_round16.sv
// fpu_mul_round16
//   Post-multiply normalize/round stage for the FP16 multiplier. It takes the raw
//   significand product, the sign and the biased exponent sum. It normalizes the
//   product one bit per cycle and denormalizes tiny results one bit per cycle.
//   It then rounds to nearest-even and emits a packed binary16 word with flags.
// Ports
//   clock      : single clock, all state updates on posedge
//   reset      : synchronous, active-high; aborts any operation in flight
//   start      : launch request, only sampled while idle
//   prodIn     : unsigned 2*FRACW-bit product, binary point below bit 2*FRACW-2
//   expIn      : signed biased exponent of the product (e1+e2-bias)
//   signIn     : result sign (s1^s2)
//   result     : {sign, exponent field, fraction field}
//   done       : one-cycle pulse when result/flags are valid
//   busy       : high in every state except idle
//   overflow   : result rounded to +/-inf
//   underflow  : result is subnormal/zero and inexact
//   inexact    : guard or sticky bits were nonzero at rounding
module fpu_mul_round16 #(
  parameter int FRACW = 11,
  parameter int EXPW  = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2*FRACW-1:0]        prodIn,
  input  logic signed [EXPW+1:0]    expIn,
  input  logic                      signIn,
  output logic [EXPW+FRACW-1:0]     result,
  output logic                      done,
  output logic                      busy,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      inexact
);

  localparam int PW = 2 * FRACW;
  localparam int CW = $clog2(PW) + 1;
  localparam int EW = EXPW + 3;
  localparam int RW = EXPW + FRACW;

  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic signed [EW-1:0] EMAX_E = EW'((2 ** EXPW) - 1);
  localparam logic [CW-1:0]        FLUSH_CNT = CW'(FRACW + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_DENORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [PW-1:0]         p_q;
  logic signed [EW-1:0]  e_q;
  logic                  sticky_q;
  logic                  sign_q;
  logic [CW-1:0]         cnt_q;
  logic [RW-1:0]         result_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  inx_q;

  // Denormalization step values
  logic [PW-1:0]         p_shr;
  logic signed [EW-1:0]  e_inc;
  logic [CW-1:0]         cnt_inc;

  // Rounding datapath
  logic                  rnd_lsb;
  logic                  rnd_g;
  logic                  rnd_s;
  logic                  rnd_up;
  logic [FRACW:0]        sig_r;
  logic                  carry_r;
  logic                  hidden_r;
  logic signed [EW-1:0]  e_r;
  logic [FRACW-2:0]      frac_r;
  logic [EXPW-1:0]       exp_field;
  logic                  ovf_r;
  logic                  inx_r;
  logic                  unf_r;
  logic [RW-1:0]         round_word;

  always_comb begin
    p_shr   = p_q >> 1;
    e_inc   = e_q + ONE_E;
    cnt_inc = cnt_q + CW'(1);

    rnd_lsb = p_q[FRACW];
    rnd_g   = p_q[FRACW-1];
    rnd_s   = sticky_q | (|p_q[FRACW-2:0]);
    rnd_up  = rnd_g & (rnd_s | rnd_lsb);

    // {hidden, frac} plus one extra bit to catch the carry out to 2.0
    sig_r    = {1'b0, p_q[PW-1:FRACW]} + {{FRACW{1'b0}}, rnd_up};
    carry_r  = sig_r[FRACW];
    // A subnormal that rounds up into the hidden bit becomes the smallest normal
    hidden_r = carry_r | sig_r[FRACW-1];
    e_r      = carry_r ? e_inc : e_q;
    frac_r   = carry_r ? '0 : sig_r[FRACW-2:0];

    exp_field = hidden_r ? e_r[EXPW-1:0] : '0;
    ovf_r     = hidden_r && (e_r >= EMAX_E);
    inx_r     = rnd_g | rnd_s;
    unf_r     = inx_r & ~hidden_r;

    if (ovf_r) begin
      round_word = {sign_q, {EXPW{1'b1}}, {(FRACW-1){1'b0}}};
    end else begin
      round_word = {sign_q, exp_field, frac_r};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      e_q      <= '0;
      sticky_q <= 1'b0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            p_q      <= prodIn;
            sign_q   <= signIn;
            // Sign-extend, then +1 so e is the exponent when p's MSB is the hidden bit
            e_q      <= {expIn[EXPW+1], expIn} + ONE_E;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
            busy_q   <= 1'b1;
            if (prodIn == '0) begin
              result_q <= {signIn, {(RW-1){1'b0}}};
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_NORM;
            end
          end
        end

        S_NORM: begin
          if (!p_q[PW-1]) begin
            p_q <= p_q << 1;
            e_q <= e_q - ONE_E;
          end else if (e_q < ONE_E) begin
            state_q <= S_DENORM;
          end else begin
            state_q <= S_ROUND;
          end
        end

        S_DENORM: begin
          cnt_q <= cnt_inc;
          if (e_inc == ONE_E) begin
            sticky_q <= sticky_q | p_q[0];
            p_q      <= p_shr;
            e_q      <= e_inc;
            state_q  <= S_ROUND;
          end else if (cnt_inc == FLUSH_CNT) begin
            // Far too small: everything left is below the guard bit
            sticky_q <= sticky_q | p_q[0] | (|p_shr);
            p_q      <= '0;
            e_q      <= ONE_E;
            state_q  <= S_ROUND;
          end else begin
            sticky_q <= sticky_q | p_q[0];
            p_q      <= p_shr;
            e_q      <= e_inc;
          end
        end

        S_ROUND: begin
          result_q <= round_word;
          ovf_q    <= ovf_r;
          unf_q    <= unf_r;
          inx_q    <= inx_r;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;

endmodule
